// File: rtl/sound_mix_seq.sv
// sound_mix_seq
// Frame sequencer in front of the serial volume multiplier-accumulator.
// A sample-rate strobe snapshots every channel's volume and sample, then the
// channels are walked through the multiplier one at a time. The accumulated
// sum is cleared at the first channel of each stereo side, and the final
// left/right pair is published together with a one-cycle strobe.
module sound_mix_seq #(
    parameter int CHANNELS = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    frame_stb,
    input  logic [6*CHANNELS-1:0]   vols,
    input  logic [8*CHANNELS-1:0]   dats,
    output logic [5:0]              mul_vol,
    output logic [7:0]              mul_dat,
    output logic                    mul_load,
    output logic                    mul_clr,
    input  logic                    mul_ready,
    input  logic [15:0]             mul_sum,
    output logic [15:0]             snd_left,
    output logic [15:0]             snd_right,
    output logic                    out_stb,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CH_W = $clog2(CHANNELS);

    localparam logic [CH_W-1:0] LAST_LEFT   = CH_W'(CHANNELS / 2 - 1);
    localparam logic [CH_W-1:0] FIRST_RIGHT = CH_W'(CHANNELS / 2);
    localparam logic [CH_W-1:0] LAST_CH     = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic [5:0]        snap_vol_q [CHANNELS];
    logic [5:0]        snap_vol_d [CHANNELS];
    logic [7:0]        snap_dat_q [CHANNELS];
    logic [7:0]        snap_dat_d [CHANNELS];

    logic [15:0]       left_hold_q, left_hold_d;
    logic [15:0]       right_hold_q, right_hold_d;

    logic [5:0]        mul_vol_q, mul_vol_d;
    logic [7:0]        mul_dat_q, mul_dat_d;
    logic              mul_load_q, mul_load_d;
    logic              mul_clr_q, mul_clr_d;
    logic [15:0]       snd_left_q, snd_left_d;
    logic [15:0]       snd_right_q, snd_right_d;
    logic              out_stb_q, out_stb_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    // State register and channel index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic: one LOAD/WAIT pair per channel, DONE after the last
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (frame_stb) begin
                    state_d = LOAD;
                    ch_d    = '0;
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        ch_d    = ch_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Snapshot capture: only an accepted frame strobe updates the copies
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            snap_vol_d[i] = snap_vol_q[i];
            snap_dat_d[i] = snap_dat_q[i];
        end
        if (state_q == IDLE && frame_stb) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                snap_vol_d[i] = vols[6*i +: 6];
                snap_dat_d[i] = dats[8*i +: 8];
            end
        end
    end

    // Snapshot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                snap_vol_q[i] <= '0;
                snap_dat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                snap_vol_q[i] <= snap_vol_d[i];
                snap_dat_q[i] <= snap_dat_d[i];
            end
        end
    end

    // Side sums are held until DONE so both outputs change on one edge
    always_comb begin
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        if (state_q == WAIT && mul_ready) begin
            if (ch_q == LAST_LEFT) begin
                left_hold_d = mul_sum;
            end
            if (ch_q == LAST_CH) begin
                right_hold_d = mul_sum;
            end
        end
    end

    // Side-sum hold registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            left_hold_q  <= '0;
            right_hold_q <= '0;
        end else begin
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
        end
    end

    // Output decode: values are prepared from the next state so every
    // output comes straight from a flop and lines up with the state it
    // belongs to (mul_load high exactly while the FSM sits in LOAD).
    always_comb begin
        mul_vol_d   = mul_vol_q;
        mul_dat_d   = mul_dat_q;
        mul_clr_d   = mul_clr_q;
        snd_left_d  = snd_left_q;
        snd_right_d = snd_right_q;

        mul_load_d  = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        out_stb_d   = (state_q == DONE);
        // A strobe seen outside IDLE (DONE included) is dropped and flagged
        // on the following cycle.
        overrun_d   = frame_stb && (state_q != IDLE);

        if (state_d == LOAD) begin
            // snap_*_d already holds the fresh copy on the IDLE->LOAD edge
            mul_vol_d = snap_vol_d[ch_d];
            mul_dat_d = snap_dat_d[ch_d];
            mul_clr_d = (ch_d == '0) || (ch_d == FIRST_RIGHT);
        end

        if (state_q == DONE) begin
            snd_left_d  = left_hold_q;
            snd_right_d = right_hold_q;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mul_vol_q   <= '0;
            mul_dat_q   <= '0;
            mul_load_q  <= 1'b0;
            mul_clr_q   <= 1'b0;
            snd_left_q  <= '0;
            snd_right_q <= '0;
            out_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mul_vol_q   <= mul_vol_d;
            mul_dat_q   <= mul_dat_d;
            mul_load_q  <= mul_load_d;
            mul_clr_q   <= mul_clr_d;
            snd_left_q  <= snd_left_d;
            snd_right_q <= snd_right_d;
            out_stb_q   <= out_stb_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mul_vol   = mul_vol_q;
    assign mul_dat   = mul_dat_q;
    assign mul_load  = mul_load_q;
    assign mul_clr   = mul_clr_q;
    assign snd_left  = snd_left_q;
    assign snd_right = snd_right_q;
    assign out_stb   = out_stb_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_mix_seq.sv
// Bench for sound_mix_seq: behavioural multiplier-accumulator, scoreboard of
// expected left/right pairs, and a linear sequence of directed steps.
module tb_sound_mix_seq;

    localparam int CH = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_stb = 1'b0;
    logic [6*CH-1:0]   vols = '0;
    logic [8*CH-1:0]   dats = '0;
    logic [5:0]        mul_vol;
    logic [7:0]        mul_dat;
    logic              mul_load;
    logic              mul_clr;
    logic              mul_ready;
    logic [15:0]       mul_sum;
    logic [15:0]       snd_left;
    logic [15:0]       snd_right;
    logic              out_stb;
    logic              busy;
    logic              overrun;

    sound_mix_seq #(.CHANNELS(CH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .frame_stb (frame_stb),
        .vols      (vols),
        .dats      (dats),
        .mul_vol   (mul_vol),
        .mul_dat   (mul_dat),
        .mul_load  (mul_load),
        .mul_clr   (mul_clr),
        .mul_ready (mul_ready),
        .mul_sum   (mul_sum),
        .snd_left  (snd_left),
        .snd_right (snd_right),
        .out_stb   (out_stb),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- behavioural multiplier-accumulator ----------------
    // Samples are sign-inverted: 0x00 -> +127, 0xFF -> -128.
    logic        m_ready = 1'b0;
    logic [15:0] m_acc   = '0;
    int          m_cnt   = 0;
    bit          lat_rand = 1'b0;

    always @(posedge clock) begin : mul_model
        int lat;
        int prod;
        if (mul_load) begin
            prod  = (127 - int'(mul_dat)) * int'(mul_vol);
            m_acc <= (mul_clr ? 16'h0000 : m_acc) + 16'(prod);
            lat   = lat_rand ? int'($urandom_range(40, 1)) : 16;
            if (lat == 1) begin
                m_ready <= 1'b1;
                m_cnt   <= 0;
            end else begin
                m_ready <= 1'b0;
                m_cnt   <= lat - 1;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_ready <= 1'b1;
        end
    end

    assign mul_ready = m_ready;
    assign mul_sum   = m_ready ? m_acc : 16'hDEAD;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [15:0] mix(input logic [6*CH-1:0] v, input logic [8*CH-1:0] d,
                                        input int first);
        int s = 0;
        for (int n = first; n < first + CH/2; n++) begin
            s += (127 - int'(d[8*n +: 8])) * int'(v[6*n +: 6]);
        end
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int         out_cnt = 0;
    int         out_cyc = 0;
    int         ovr_cnt = 0;
    int         ovr_cyc = 0;
    int         busy_cnt = 0;
    int         load_cyc[$];
    bit         load_clr[$];
    logic [5:0] load_vol[$];
    logic [7:0] load_dat[$];

    always @(negedge clock) begin : monitor
        exp_t e;
        if (mul_load) begin
            load_cyc.push_back(cyc);
            load_clr.push_back(mul_clr);
            load_vol.push_back(mul_vol);
            load_dat.push_back(mul_dat);
        end
        if (busy) busy_cnt++;
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (out_stb) begin
            out_cnt++;
            out_cyc = cyc;
            n_vec++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL out_stb_unexpected: observed out_stb with empty scoreboard, expected none");
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("snd_left", 32'(snd_left), 32'(e.l));
                check("snd_right", 32'(snd_right), 32'(e.r));
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_mon();
        load_cyc.delete();
        load_clr.delete();
        load_vol.delete();
        load_dat.delete();
        busy_cnt = 0;
    endtask

    // Drive an accepted strobe with the given data; s = cycle of the strobe.
    task automatic start_frame(input logic [6*CH-1:0] v, input logic [8*CH-1:0] d, output int s);
        exp_t e;
        vols      = v;
        dats      = d;
        frame_stb = 1'b1;
        s         = cyc;
        e.l       = mix(v, d, 0);
        e.r       = mix(v, d, CH/2);
        sb_q.push_back(e);
        @(negedge clock);
        frame_stb = 1'b0;
    endtask

    task automatic wait_out(input int target, input string tag);
        int k = 0;
        while (out_cnt < target && k < 400) begin
            @(negedge clock);
            #1;
            k++;
        end
        check(tag, 32'(out_cnt), 32'(target));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int s, s2, base, ovr_base, exp_ovr, k;
        logic [6*CH-1:0] v;
        logic [8*CH-1:0] d;
        logic [3:0] clr_pat;

        // Reset state
        tick(3);
        check("rst_mul_load", 32'(mul_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_stb", 32'(out_stb), 32'd0);
        check("rst_snd_left", 32'(snd_left), 32'd0);
        check("rst_snd_right", 32'(snd_right), 32'd0);
        check("rst_mul_vol_dat_clr", {17'd0, mul_clr, mul_vol, mul_dat}, 32'd0);
        reset_n = 1'b1;

        // Idle for 100 cycles: nothing moves
        clear_mon();
        tick(100);
        #1;
        check("idle_loads", 32'(load_cyc.size()), 32'd0);
        check("idle_busy", 32'(busy_cnt), 32'd0);
        check("idle_out_stb", 32'(out_cnt), 32'd0);
        check("idle_overrun", 32'(ovr_cnt), 32'd0);

        // Directed frame: all volumes 63, channels 0,1 = 0x00, 2,3 = 0xFF
        @(negedge clock);
        clear_mon();
        base = out_cnt;
        ovr_base = ovr_cnt;
        start_frame({CH{6'd63}}, 32'hFFFF_0000, s);
        wait_out(base + 1, "t2_out_stb");
        check("t2_out_latency", 32'(out_cyc - s), 32'd70);
        check("t2_load_count", 32'(load_cyc.size()), 32'd4);
        if (load_cyc.size() == 4) begin
            check("t2_first_load", 32'(load_cyc[0] - s), 32'd1);
            for (int i = 1; i < 4; i++) check("t2_load_gap", 32'(load_cyc[i] - load_cyc[i-1]), 32'd17);
            clr_pat = {load_clr[0], load_clr[1], load_clr[2], load_clr[3]};
            check("t2_clr_pattern", 32'(clr_pat), 32'b1010);
        end
        check("t2_busy_cycles", 32'(busy_cnt), 32'd69);
        check("t2_snd_right", 32'(snd_right), 32'h0000_C100);
        check("t2_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

        // Inputs change every cycle after the strobe: snapshot must be used
        tick(2);
        clear_mon();
        base = out_cnt;
        v = 24'($urandom);
        d = $urandom;
        start_frame(v, d, s);
        k = 0;
        while (out_cnt < base + 1 && k < 200) begin
            vols = 24'($urandom);
            dats = $urandom;
            @(negedge clock);
            #1;
            k++;
        end
        check("t3_out_stb", 32'(out_cnt), 32'(base + 1));
        check("t3_load_count", 32'(load_cyc.size()), 32'd4);
        if (load_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_load_vol", 32'(load_vol[i]), 32'(v[6*i +: 6]));
                check("t3_load_dat", 32'(load_dat[i]), 32'(d[8*i +: 8]));
            end
        end

        // Strobe at cycle 30 of a frame is dropped and flagged
        tick(3);
        base = out_cnt;
        ovr_base = ovr_cnt;
        start_frame(24'($urandom), $urandom, s);
        tick(29);
        vols = 24'($urandom);
        dats = $urandom;
        frame_stb = 1'b1;
        tick(1);
        frame_stb = 1'b0;
        wait_out(base + 1, "t4_out_stb");
        check("t4_overrun_count", 32'(ovr_cnt - ovr_base), 32'd1);
        check("t4_overrun_cycle", 32'(ovr_cyc - s), 32'd31);
        tick(20);
        #1;
        check("t4_single_out_stb", 32'(out_cnt), 32'(base + 1));

        // Strobe in DONE is dropped; strobe one cycle later starts a new frame
        base = out_cnt;
        ovr_base = ovr_cnt;
        start_frame(24'($urandom), $urandom, s);
        tick(68);
        vols = 24'($urandom);
        dats = $urandom;
        frame_stb = 1'b1;
        tick(1);
        start_frame(24'($urandom), $urandom, s2);
        wait_out(base + 2, "t5_out_stb");
        check("t5_overrun_count", 32'(ovr_cnt - ovr_base), 32'd1);
        check("t5_overrun_cycle", 32'(ovr_cyc - s), 32'd70);
        check("t5_back_to_back_latency", 32'(out_cyc - s2), 32'd70);

        // Reset during WAIT of channel 2
        tick(2);
        clear_mon();
        start_frame(24'($urandom), $urandom, s);
        k = 0;
        while (load_cyc.size() < 3 && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("t6_reached_ch2", 32'(load_cyc.size()), 32'd3);
        tick(5);
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_mul_load", 32'(mul_load), 32'd0);
        check("t6_rst_out_stb", 32'(out_stb), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_snd", {snd_left, snd_right}, 32'd0);
        check("t6_rst_mul_vol_dat_clr", {17'd0, mul_clr, mul_vol, mul_dat}, 32'd0);
        sb_q.delete();
        tick(3);
        reset_n = 1'b1;
        tick(2);
        clear_mon();
        base = out_cnt;
        start_frame(24'($urandom), $urandom, s);
        wait_out(base + 1, "t6_out_stb_after_reset");
        check("t6_load_count", 32'(load_cyc.size()), 32'd4);
        check("t6_out_latency", 32'(out_cyc - s), 32'd70);

        // Random ready latency and data
        lat_rand = 1'b1;
        base = out_cnt;
        ovr_base = ovr_cnt;
        exp_ovr = 0;
        for (int f = 0; f < 400; f++) begin
            tick($urandom_range(3, 0));
            start_frame(24'($urandom), $urandom, s);
            if ($urandom_range(3, 0) == 0) begin
                vols = 24'($urandom);
                dats = $urandom;
                frame_stb = 1'b1;
                tick(1);
                frame_stb = 1'b0;
                exp_ovr++;
            end
            wait_out(base + f + 1, "t7_out_stb");
        end
        tick(50);
        #1;
        check("t7_out_count", 32'(out_cnt - base), 32'd400);
        check("t7_overrun_count", 32'(ovr_cnt - ovr_base), 32'(exp_ovr));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
